// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full_adder slice.
//   adder_res_t : packed result {cout, s}
//   FA_LATENCY  : cycles from a valid input edge to its result when registered
package full_adder_pkg;

   typedef struct packed {
      logic cout;
      logic s;
   } adder_res_t;

   localparam int unsigned FA_LATENCY = 1;

endpackage : full_adder_pkg

// File: rtl/half_adder.sv
// Half adder: sum = x ^ y, carry = x & y.
// Ports:
//   x, y  : addend bits
//   sum   : sum bit
//   carry : carry bit
module half_adder (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);

   assign sum   = x ^ y;
   assign carry = x & y;

endmodule : half_adder

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders, with an optional output
// register stage.
// Parameters:
//   OUT_REG : 1 = registered outputs (one-cycle latency), 0 = combinational
// Ports:
//   clk, rst  : clock and asynchronous active-high reset (unused if OUT_REG=0)
//   in_valid  : a, b, cin carry an operand set this cycle
//   a, b, cin : addends and carry-in
//   out_valid : s and cout hold a fresh result
//   s, cout   : sum and carry-out
module full_adder
   import full_adder_pkg::*;
#(
   parameter bit OUT_REG = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic out_valid,
   output logic s,
   output logic cout
);

   logic       w_ha0_sum;
   logic       w_ha0_carry;
   logic       w_ha1_carry;
   adder_res_t w_res;

   half_adder u_ha0 (
      .x     (a),
      .y     (b),
      .sum   (w_ha0_sum),
      .carry (w_ha0_carry)
   );

   half_adder u_ha1 (
      .x     (w_ha0_sum),
      .y     (cin),
      .sum   (w_res.s),
      .carry (w_ha1_carry)
   );

   // The two carries can never both be set, so OR equals majority(a, b, cin).
   assign w_res.cout = w_ha0_carry | w_ha1_carry;

   generate
      if (OUT_REG) begin : g_reg
         adder_res_t r_res;
         logic       r_valid;

         // Result holds across idle cycles; out_valid pulses for one cycle
         // per accepted operand set.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_res   <= '0;
               r_valid <= 1'b0;
            end else begin
               r_valid <= in_valid;
               if (in_valid) begin
                  r_res <= w_res;
               end
            end
         end

         assign s         = r_res.s;
         assign cout      = r_res.cout;
         assign out_valid = r_valid;
      end else begin : g_comb
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = clk ^ rst;

         assign s         = w_res.s;
         assign cout      = w_res.cout;
         assign out_valid = in_valid;
      end
   endgenerate

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: registered build (default)
// and combinational build (OUT_REG=0) side by side.
module tb_full_adder;
   import full_adder_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, a, b, cin;
   logic out_valid, s, cout;

   logic c_in_valid, c_a, c_b, c_cin;
   logic c_out_valid, c_s, c_cout;

   int unsigned n_checks   = 0;
   int unsigned n_failures = 0;

   // Hand-computed {s, cout} indexed by {a, b, cin}.
   logic [1:0] exp_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01,
                              2'b10, 2'b01, 2'b01, 2'b11};

   always #5 clk = ~clk;

   full_adder #(.OUT_REG(1'b1)) u_dut_reg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .s         (s),
      .cout      (cout)
   );

   full_adder #(.OUT_REG(1'b0)) u_dut_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .a         (c_a),
      .b         (c_b),
      .cin       (c_cin),
      .out_valid (c_out_valid),
      .s         (c_s),
      .cout      (c_cout)
   );

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, then sample 1 ns after the next rising edge.
   task automatic drive_and_step(input logic v, input logic [2:0] abc);
      @(negedge clk);
      in_valid = v;
      {a, b, cin} = abc;
      repeat (FA_LATENCY) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
      c_in_valid = 1'b0; c_a = 1'b0; c_b = 1'b0; c_cin = 1'b0;

      // Reset state, with and without clock edges.
      #2;
      check("reset_pre_edge", {out_valid, s, cout}, 3'b000);
      @(posedge clk); #1;
      check("reset_post_edge", {out_valid, s, cout}, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive sweep, back-to-back.
      for (int unsigned i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         drive_and_step(1'b1, v);
         check($sformatf("sweep_%b", v), {out_valid, s, cout}, {1'b1, exp_sc[i]});
      end

      // Single valid then idle: out_valid for exactly one cycle, result held.
      drive_and_step(1'b1, 3'b110);
      check("hold_load", {out_valid, s, cout}, 3'b101);
      for (int unsigned k = 0; k < 3; k++) begin
         drive_and_step(1'b0, 3'b111);
         check($sformatf("hold_idle_%0d", k), {out_valid, s, cout}, 3'b001);
      end

      // Back-to-back stream with no bubbles.
      drive_and_step(1'b1, 3'b001);
      check("b2b_0", {out_valid, s, cout}, 3'b110);
      drive_and_step(1'b1, 3'b101);
      check("b2b_1", {out_valid, s, cout}, 3'b101);
      drive_and_step(1'b1, 3'b111);
      check("b2b_2", {out_valid, s, cout}, 3'b111);

      // Async reset between edges while s=1, cout=1 and a result is in flight.
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", {out_valid, s, cout}, 3'b000);
      @(negedge clk);
      check("async_reset_held", {out_valid, s, cout}, 3'b000);
      rst = 1'b0;
      in_valid = 1'b0;

      // First valid edge after reset release.
      drive_and_step(1'b1, 3'b101);
      check("post_reset_first", {out_valid, s, cout}, 3'b101);
      drive_and_step(1'b0, 3'b000);
      check("post_reset_idle", {out_valid, s, cout}, 3'b001);

      // Combinational build.
      c_in_valid = 1'b1; {c_a, c_b, c_cin} = 3'b100;
      #1;
      check("comb_100", {c_out_valid, c_s, c_cout}, 3'b110);
      c_in_valid = 1'b0;
      #1;
      check("comb_valid_low", {c_out_valid, c_s, c_cout}, 3'b010);
      for (int unsigned i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         c_in_valid = i[0];
         {c_a, c_b, c_cin} = v;
         #1;
         check($sformatf("comb_%b", v), {c_out_valid, c_s, c_cout}, {i[0], exp_sc[i]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule : tb_full_adder
